// File: rtl/dp_ram_bwe_if.sv
// Request/response bundle for both ports of dp_ram_bwe, plus the memory-wide
// status flags. The master drives requests; the RAM (slave) drives responses.
interface dp_ram_bwe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned BYTE_W = 8
);
    localparam int unsigned NB = DATA_W / BYTE_W;

    logic              en_a;
    logic              we_a;
    logic [NB-1:0]     be_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] rdata_a;
    logic              rvalid_a;

    logic              en_b;
    logic              we_b;
    logic [NB-1:0]     be_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic [DATA_W-1:0] rdata_b;
    logic              rvalid_b;

    logic              init_busy;
    logic              collision;

    modport master (
        output en_a, we_a, be_a, addr_a, wdata_a,
        output en_b, we_b, be_b, addr_b, wdata_b,
        input  rdata_a, rvalid_a, rdata_b, rvalid_b, init_busy, collision
    );

    modport slave (
        input  en_a, we_a, be_a, addr_a, wdata_a,
        input  en_b, we_b, be_b, addr_b, wdata_b,
        output rdata_a, rvalid_a, rdata_b, rvalid_b, init_busy, collision
    );
endinterface

// File: rtl/dp_ram_bwe.sv
// True dual-port RAM with byte-lane write enables, selectable read-during-write,
// optional output register, post-reset memory clear and same-address collision flag.
module dp_ram_bwe #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned BYTE_W       = 8,
    parameter int unsigned RDW_MODE     = 0,
    parameter int unsigned OUT_REG      = 0,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic         clk,
    input  logic         rst,
    dp_ram_bwe_if.slave  bus
);
    localparam int unsigned NB    = DATA_W / BYTE_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_CLEAR, S_READY} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              busy, clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_a, acc_b, wr_a, wr_b, same_addr;
    logic [DATA_W-1:0] old_a, old_b, fin_a, fin_b, ret_a, ret_b;

    logic              rv1_a_q, rv1_b_q;
    logic [DATA_W-1:0] rd1_a_q, rd1_b_q;
    logic              rvalid_a_q, rvalid_b_q, coll_q;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;

    // Clear sequencer: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Clear sequencer: next state; the counter parks on the last word instead of wrapping
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (CLEAR_ON_RST == 0) begin
            state_d = S_READY;
        end else if (state_q == S_CLEAR) begin
            if (clr_addr_q == '1) begin
                state_d = S_READY;
            end else begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
            end
        end
    end

    // Clear sequencer: outputs
    always_comb begin
        busy   = (state_q == S_CLEAR);
        clr_we = busy & ~rst;
    end

    always_comb begin
        acc_a     = bus.en_a & ~busy & ~rst;
        acc_b     = bus.en_b & ~busy & ~rst;
        wr_a      = acc_a & bus.we_a;
        wr_b      = acc_b & bus.we_b;
        same_addr = acc_a & acc_b & (bus.addr_a == bus.addr_b);
        old_a     = mem[bus.addr_a];
        old_b     = mem[bus.addr_b];
    end

    // Final stored word as each port sees it, with port A owning contested lanes
    always_comb begin
        fin_a = old_a;
        fin_b = old_b;
        for (int unsigned i = 0; i < NB; i++) begin
            if (same_addr && wr_b && bus.be_b[i])
                fin_a[i*BYTE_W +: BYTE_W] = bus.wdata_b[i*BYTE_W +: BYTE_W];
            if (wr_a && bus.be_a[i])
                fin_a[i*BYTE_W +: BYTE_W] = bus.wdata_a[i*BYTE_W +: BYTE_W];
            if (wr_b && bus.be_b[i])
                fin_b[i*BYTE_W +: BYTE_W] = bus.wdata_b[i*BYTE_W +: BYTE_W];
            if (same_addr && wr_a && bus.be_a[i])
                fin_b[i*BYTE_W +: BYTE_W] = bus.wdata_a[i*BYTE_W +: BYTE_W];
        end
        ret_a = (wr_a && RDW_MODE == 0) ? fin_a : old_a;
        ret_b = (wr_b && RDW_MODE == 0) ? fin_b : old_b;
    end

    // Port B lanes are written before port A so A's later assignment wins on overlap
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr_q] <= '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr_b && bus.be_b[i])
                mem[bus.addr_b][i*BYTE_W +: BYTE_W] <= bus.wdata_b[i*BYTE_W +: BYTE_W];
            if (wr_a && bus.be_a[i])
                mem[bus.addr_a][i*BYTE_W +: BYTE_W] <= bus.wdata_a[i*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rv1_a_q    <= 1'b0;
            rv1_b_q    <= 1'b0;
            rd1_a_q    <= '0;
            rd1_b_q    <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            coll_q     <= 1'b0;
        end else begin
            coll_q  <= same_addr & (wr_a | wr_b);
            rv1_a_q <= acc_a;
            rv1_b_q <= acc_b;
            if (acc_a) rd1_a_q <= ret_a;
            if (acc_b) rd1_b_q <= ret_b;
            if (OUT_REG != 0) begin
                rvalid_a_q <= rv1_a_q;
                rvalid_b_q <= rv1_b_q;
                if (rv1_a_q) rdata_a_q <= rd1_a_q;
                if (rv1_b_q) rdata_b_q <= rd1_b_q;
            end else begin
                rvalid_a_q <= acc_a;
                rvalid_b_q <= acc_b;
                if (acc_a) rdata_a_q <= ret_a;
                if (acc_b) rdata_b_q <= ret_b;
            end
        end
    end

    assign bus.rdata_a   = rdata_a_q;
    assign bus.rvalid_a  = rvalid_a_q;
    assign bus.rdata_b   = rdata_b_q;
    assign bus.rvalid_b  = rvalid_b_q;
    assign bus.init_busy = busy;
    assign bus.collision = coll_q;
endmodule

// File: tb/tb_dp_ram_bwe.sv
// Self-checking bench: three dp_ram_bwe variants (write-first, read-first,
// registered output) share one stimulus stream and one word-level reference model.
module tb_dp_ram_bwe;
    localparam int DW = 32, AW = 4, BW = 8, NB = 4, DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          en_a, we_a, en_b, we_b;
    logic [NB-1:0] be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;

    logic          o_rva [3], o_rvb [3], o_col [3], o_busy [3];
    logic [DW-1:0] o_rda [3], o_rdb [3];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dp_ram_bwe_if #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW)) bus ();
        assign bus.en_a    = en_a;
        assign bus.we_a    = we_a;
        assign bus.be_a    = be_a;
        assign bus.addr_a  = addr_a;
        assign bus.wdata_a = wdata_a;
        assign bus.en_b    = en_b;
        assign bus.we_b    = we_b;
        assign bus.be_b    = be_b;
        assign bus.addr_b  = addr_b;
        assign bus.wdata_b = wdata_b;
        assign o_rva[g]    = bus.rvalid_a;
        assign o_rvb[g]    = bus.rvalid_b;
        assign o_rda[g]    = bus.rdata_a;
        assign o_rdb[g]    = bus.rdata_b;
        assign o_col[g]    = bus.collision;
        assign o_busy[g]   = bus.init_busy;
        dp_ram_bwe #(
            .DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW),
            .RDW_MODE(g == 1 ? 1 : 0), .OUT_REG(g == 2 ? 1 : 0), .CLEAR_ON_RST(1)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    // Reference model: DUT 0 write-first, DUT 1 read-first, DUT 2 write-first + 2-cycle latency
    logic [DW-1:0] mem_m [DEPTH];
    int            busy_m;
    logic          ev_a [3], ev_b [3], e_col;
    logic [DW-1:0] ed_a [3], ed_b [3];
    logic          pv_a, pv_b;
    logic [DW-1:0] pd_a, pd_b;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] w,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < NB; i++) if (be[i]) mask |= 32'hFF << (8 * i);
        return (old & ~mask) | (w & mask);
    endfunction

    task automatic model_edge();
        logic          acc_a, acc_b;
        logic [DW-1:0] old_a, old_b, new_a, new_b;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            busy_m = DEPTH;
            for (int d = 0; d < 3; d++) begin
                ev_a[d] = 1'b0; ev_b[d] = 1'b0; ed_a[d] = '0; ed_b[d] = '0;
            end
            pv_a = 1'b0; pv_b = 1'b0; pd_a = '0; pd_b = '0; e_col = 1'b0;
            return;
        end
        acc_a = en_a && busy_m == 0;
        acc_b = en_b && busy_m == 0;
        if (busy_m > 0) busy_m--;
        old_a = mem_m[addr_a];
        old_b = mem_m[addr_b];
        e_col = acc_a && acc_b && addr_a == addr_b && (we_a || we_b);
        if (acc_b && we_b) mem_m[addr_b] = merge(mem_m[addr_b], wdata_b, be_b);
        if (acc_a && we_a) mem_m[addr_a] = merge(mem_m[addr_a], wdata_a, be_a);
        new_a = (acc_a && we_a) ? mem_m[addr_a] : old_a;
        new_b = (acc_b && we_b) ? mem_m[addr_b] : old_b;
        ev_a[0] = acc_a; if (acc_a) ed_a[0] = new_a;
        ev_b[0] = acc_b; if (acc_b) ed_b[0] = new_b;
        ev_a[1] = acc_a; if (acc_a) ed_a[1] = old_a;
        ev_b[1] = acc_b; if (acc_b) ed_b[1] = old_b;
        ev_a[2] = pv_a;  if (pv_a) ed_a[2] = pd_a;
        ev_b[2] = pv_b;  if (pv_b) ed_b[2] = pd_b;
        pv_a = acc_a; if (acc_a) pd_a = new_a;
        pv_b = acc_b; if (acc_b) pd_b = new_b;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("busy%0d", d), o_busy[d], busy_m > 0);
            check($sformatf("rvalid_a%0d", d), o_rva[d], ev_a[d]);
            check($sformatf("rvalid_b%0d", d), o_rvb[d], ev_b[d]);
            check($sformatf("rdata_a%0d", d), o_rda[d], ed_a[d]);
            check($sformatf("rdata_b%0d", d), o_rdb[d], ed_b[d]);
            check($sformatf("collision%0d", d), o_col[d], e_col);
        end
    endtask

    task automatic drive(input logic ea, input logic wa, input logic [3:0] ba, input logic [3:0] aa,
                         input logic [31:0] da, input logic eb, input logic wb, input logic [3:0] bb,
                         input logic [3:0] ab, input logic [31:0] db);
        en_a = ea; we_a = wa; be_a = ba; addr_a = aa; wdata_a = da;
        en_b = eb; we_b = wb; be_b = bb; addr_b = ab; wdata_b = db;
    endtask

    task automatic idle();
        drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (o_busy[0] && n < 40) begin
            step();
            n++;
        end
        check(nm, n, 16);
    endtask

    typedef struct {
        logic ea, wa; logic [3:0] ba, aa; logic [31:0] da;
        logic eb, wb; logic [3:0] bb, ab; logic [31:0] db;
        logic xva; logic [31:0] xda, xda1; logic xvb; logic [31:0] xdb; logic xcol;
    } vec_t;

    vec_t tv [12];

    initial begin
        tv[0]  = '{1,1,4'hF,4'd5,32'h11223344, 0,0,4'h0,4'd0,32'h0,        1,32'h11223344,32'h00000000, 0,32'h00000000, 0};
        tv[1]  = '{1,1,4'h5,4'd5,32'hAABBCCDD, 0,0,4'h0,4'd0,32'h0,        1,32'h11BB33DD,32'h11223344, 0,32'h00000000, 0};
        tv[2]  = '{1,0,4'h0,4'd5,32'h0,        0,0,4'h0,4'd0,32'h0,        1,32'h11BB33DD,32'h11BB33DD, 0,32'h00000000, 0};
        tv[3]  = '{1,1,4'hF,4'd6,32'h11223344, 0,0,4'h0,4'd0,32'h0,        1,32'h11223344,32'h00000000, 0,32'h00000000, 0};
        tv[4]  = '{1,1,4'h3,4'd6,32'h0000BEEF, 0,0,4'h0,4'd0,32'h0,        1,32'h1122BEEF,32'h11223344, 0,32'h00000000, 0};
        tv[5]  = '{1,0,4'h0,4'd6,32'h0,        0,0,4'h0,4'd0,32'h0,        1,32'h1122BEEF,32'h1122BEEF, 0,32'h00000000, 0};
        tv[6]  = '{1,1,4'h3,4'd7,32'hAAAAAAAA, 1,1,4'h6,4'd7,32'hBBBBBBBB, 1,32'h00BBAAAA,32'h00000000, 1,32'h00BBAAAA, 1};
        tv[7]  = '{1,0,4'h0,4'd7,32'h0,        0,0,4'h0,4'd0,32'h0,        1,32'h00BBAAAA,32'h00BBAAAA, 0,32'h00BBAAAA, 0};
        tv[8]  = '{1,1,4'hF,4'd9,32'h12345678, 0,0,4'h0,4'd0,32'h0,        1,32'h12345678,32'h00000000, 0,32'h00BBAAAA, 0};
        tv[9]  = '{1,1,4'hF,4'd9,32'hCAFEF00D, 1,0,4'h0,4'd9,32'h0,        1,32'hCAFEF00D,32'h12345678, 1,32'h12345678, 1};
        tv[10] = '{1,0,4'h0,4'd9,32'h0,        1,0,4'h0,4'd9,32'h0,        1,32'hCAFEF00D,32'hCAFEF00D, 1,32'hCAFEF00D, 0};
        tv[11] = '{0,0,4'h0,4'd0,32'h0,        0,0,4'h0,4'd0,32'h0,        0,32'hCAFEF00D,32'hCAFEF00D, 0,32'hCAFEF00D, 0};

        // Reset and initial clear
        rst = 1'b1;
        idle();
        step();
        check("reset_busy", o_busy[0], 1);
        check("reset_rvalid", o_rva[0], 0);
        step();
        rst = 1'b0;
        count_busy("clear_len_first");

        // Clear wipes earlier contents; requests during the sweep are dropped
        drive(1, 1, 4'hF, 4'd3, 32'hDEADBEEF, 0, 0, 4'h0, 4'd0, 32'h0);
        step();
        check("t1_write", o_rda[0], 32'hDEADBEEF);
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        drive(1, 0, 4'h0, 4'd3, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0);
        begin
            int n;
            n = 0;
            while (o_busy[0] && n < 40) begin
                step();
                check("t1_busy_drop", o_rva[0], 0);
                n++;
            end
            check("t1_clear_len", n, 16);
        end
        step();
        check("t1_read_valid", o_rva[0], 1);
        check("t1_read_zero", o_rda[0], 32'h0);

        // Reset re-asserted mid-sweep restarts the full sweep
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("t1_mid_busy", o_busy[0], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("clear_len_restart");

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].ea, tv[i].wa, tv[i].ba, tv[i].aa, tv[i].da,
                  tv[i].eb, tv[i].wb, tv[i].bb, tv[i].ab, tv[i].db);
            step();
            check($sformatf("tv%0d_rvalid_a", i), o_rva[0], tv[i].xva);
            check($sformatf("tv%0d_rdata_a", i), o_rda[0], tv[i].xda);
            check($sformatf("tv%0d_rdata_a_rf", i), o_rda[1], tv[i].xda1);
            check($sformatf("tv%0d_rvalid_b", i), o_rvb[0], tv[i].xvb);
            check($sformatf("tv%0d_rdata_b", i), o_rdb[0], tv[i].xdb);
            check($sformatf("tv%0d_collision", i), o_col[0], tv[i].xcol);
        end

        // Registered-output latency with a collision on the first read
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 4'hF, 4'(i), 32'hA0000000 + 32'(i), 0, 0, 4'h0, 4'd0, 32'h0);
            step();
        end
        idle();
        step();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(1, 0, 4'h0, 4'(k), 32'h0, k == 0, k == 0, 4'h0, 4'd0, 32'hFFFFFFFF);
            else idle();
            step();
            check($sformatf("t6_rvalid_k%0d", k), o_rva[2], (k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) check($sformatf("t6_rdata_k%0d", k), o_rda[2], 32'hA0000000 + 32'(k - 1));
            check($sformatf("t6_collision_k%0d", k), o_col[2], k == 0);
        end

        // Randomized traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            en_a = ($urandom_range(0, 9) < 7);
            we_a = $urandom_range(0, 1);
            be_a = 4'($urandom);
            addr_a = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            wdata_a = $urandom;
            en_b = ($urandom_range(0, 9) < 7);
            we_b = $urandom_range(0, 1);
            be_b = 4'($urandom);
            addr_b = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            wdata_b = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dp_ram_bwe.md
Name: dp_ram_bwe

Overview:
Parametrised true dual-port synchronous RAM with per-byte write enables. Each port has a selectable read-during-write result and an optional output pipeline register. Adds a reset-triggered memory-clear sequencer and same-address collision detection. It is the data/scratch memory building block for the pipelined core and its peripherals; both ports serve independent masters.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of BYTE_W
ADDR_W, 10, address width; DEPTH = 2**ADDR_W words
BYTE_W, 8, byte-lane width; NB = DATA_W/BYTE_W lanes
RDW_MODE, 0, same-port write result: 0 = write-first (merged new word), 1 = read-first (old word)
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, latency 2
CLEAR_ON_RST, 1, 1 = zero every word after reset; 0 = reset leaves contents untouched

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  synchronous active-high reset
en_a  in  1  port A access request
we_a  in  1  port A write (valid with en_a)
be_a  in  NB  port A byte-lane enables
addr_a  in  ADDR_W  port A word address
wdata_a  in  DATA_W  port A write data
rdata_a  out  DATA_W  port A read/return data
rvalid_a  out  1  port A rdata valid pulse
en_b, we_b, be_b, addr_b, wdata_b, rdata_b, rvalid_b: same as port A, for port B
init_busy  out  1  clear sequence in progress; all requests ignored
collision  out  1  one-cycle pulse: same-address access with at least one write

Behaviour:
- Reset (rst=1 at a clk edge): rdata_a/b=0, rvalid_a/b=0, collision=0, all pipeline stages cleared, clr_addr=0. init_busy=1 if CLEAR_ON_RST, otherwise 0. No memory writes occur while rst=1.
- Clear FSM (CLEAR_ON_RST=1) has two states, CLEAR and READY. rst forces CLEAR.
  - In CLEAR with rst=0: each cycle writes mem[clr_addr] to 0 and increments clr_addr.
  - When clr_addr==DEPTH-1 is written, the next state is READY.
  - init_busy = (state==CLEAR). It stays high exactly DEPTH cycles after rst deasserts.
  - rst asserted mid-clear restarts the sweep at address 0.
  - With CLEAR_ON_RST=0 the FSM is held in READY.
- Acceptance: a port access is accepted when en_x=1 and init_busy=0.
  - Requests during init_busy are dropped. They are not queued and produce no rvalid.
  - we_x or be_x is ignored when en_x=0. A write with be_x=0 updates nothing but still returns rvalid.
- Latency: every accepted access (read or write) gives rvalid_x=1 for exactly one cycle. This is cycle N+1 when OUT_REG=0 and N+2 when OUT_REG=1. Fully pipelined: one access per port per cycle.
- rdata holds its last value while rvalid=0. It is never zeroed except by reset.
- Write: lanes with be set take wdata; other lanes keep their stored value.
- Same-port write return: RDW_MODE=0 returns the merged new word. RDW_MODE=1 returns the pre-write word.
- Collision (both ports accepted, addr_a==addr_b, we_a|we_b):
  - Both write: per lane, port A wins where both be are set. Lanes enabled only by B take wdata_b.
  - One reads, the other writes: the reading port always gets the old word, regardless of RDW_MODE.
  - Each writing port's own return follows RDW_MODE using the final merged word.
  - collision=1 at cycle N+1 for one cycle. It is not delayed by OUT_REG.
- Same-address reads on both ports: both return the stored word; collision=0.
- Address arithmetic: the clear counter is ADDR_W bits and never wraps past DEPTH-1 during the sweep.

Test Plan:
(DATA_W=32, ADDR_W=4, DEPTH=16, OUT_REG=0, RDW_MODE=0 unless stated)
1. Write 0xDEADBEEF to A addr 3, pulse rst 1 cycle -> init_busy=1 for 16 cycles; A read issued during busy gives no rvalid; afterwards read addr 3 -> rdata_a=0x00000000. Repeat with rst re-asserted at sweep cycle 8 -> busy lasts 16 more cycles.
2. A writes 0x11223344 be=1111 to addr 5, then 0xAABBCCDD be=0101 -> read addr 5 gives 0x11BB33DD, rvalid_a one cycle after each access.
3. Addr 6 holds 0x11223344; A writes 0x0000BEEF be=0011 -> rdata_a=0x1122BEEF. With RDW_MODE=1 -> rdata_a=0x11223344; subsequent read gives 0x1122BEEF in both modes.
4. Addr 7 = 0 after clear; same cycle A writes 0xAAAAAAAA be=0011 and B writes 0xBBBBBBBB be=0110 -> collision=1 for one cycle; read addr 7 = 0x00BBAAAA.
5. Addr 9 holds 0x12345678; A writes 0xCAFEF00D be=1111 while B reads addr 9 -> rdata_b=0x12345678, collision=1; next B read gives 0xCAFEF00D. Both ports read addr 9 together -> collision=0.
6. OUT_REG=1: back-to-back A reads of addr 0..3 on cycles N..N+3 -> rvalid_a high on N+2..N+5 with data in order; collision from test 4 still appears at N+1.
